// File: rtl/iob_reset_seq_pkg.sv
// Shared state encodings and sizing helpers for the staged reset sequencer.
package iob_reset_seq_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_HOLD     = 3'd0,
      ST_WAIT_RDY = 3'd1,
      ST_STAGE    = 3'd2,
      ST_RUN      = 3'd3,
      ST_ERR      = 3'd4
   } state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/iob_sync.sv
// Two-flop synchroniser for asynchronous level flags, clears to 0 on reset.
module iob_sync #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/iob_reset_seq.sv
// Reset sequencer: waits for synchronised ready flags, holds reset for a minimum
// time, then releases reset domains one by one; any ready loss restarts it.
module iob_reset_seq
   import iob_reset_seq_pkg::*;
#(
   parameter int unsigned N_RDY     = 2,
   parameter int unsigned N_OUT     = 2,
   parameter int unsigned HOLD_CYC  = 16,
   parameter int unsigned STAGE_CYC = 4,
   parameter int unsigned TO_CYC    = 1000000
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               soft_rst_i,
   input  logic [N_RDY-1:0]   rdy_i,
   output logic [N_OUT-1:0]   rst_o,
   output logic [N_RDY-1:0]   rdy_sync_o,
   output logic [STATE_W-1:0] state_o,
   output logic               timeout_o
);

   localparam int unsigned CNT_W = $clog2(max3(HOLD_CYC, STAGE_CYC, TO_CYC) + 1);
   localparam int unsigned IDX_W = $clog2(N_OUT + 1);

   logic [N_RDY-1:0] rdy_sync;
   logic             all_rdy;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N_OUT-1:0] rst_q, rst_d;
   logic             to_q, to_d;

   iob_sync #(
      .WIDTH (N_RDY)
   ) u_sync (
      .clk   (clk),
      .rst_n (resetn),
      .d_i   (rdy_i),
      .q_o   (rdy_sync)
   );

   assign all_rdy = &rdy_sync;

   // Next-state logic; soft restart overrides every other transition.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      to_d    = to_q;

      if (soft_rst_i) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         rst_d   = '1;
         to_d    = 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               rst_d = '1;
               if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                  state_d = ST_WAIT_RDY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            ST_WAIT_RDY: begin
               rst_d = '1;
               if (all_rdy) begin
                  state_d = ST_STAGE;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else if (cnt_q == CNT_W'(TO_CYC - 1)) begin
                  state_d = ST_ERR;
                  cnt_d   = '0;
                  to_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            ST_STAGE: begin
               if (!all_rdy) begin
                  state_d = ST_HOLD;
                  cnt_d   = '0;
                  idx_d   = '0;
                  rst_d   = '1;
               end else if (cnt_q == CNT_W'(STAGE_CYC - 1)) begin
                  for (int unsigned k = 0; k < N_OUT; k++) begin
                     if (idx_q == IDX_W'(k)) rst_d[k] = 1'b0;
                  end
                  cnt_d = '0;
                  idx_d = idx_q + IDX_W'(1);
                  if (idx_q == IDX_W'(N_OUT - 1)) state_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            ST_RUN: begin
               if (!all_rdy) begin
                  state_d = ST_HOLD;
                  cnt_d   = '0;
                  idx_d   = '0;
                  rst_d   = '1;
               end else begin
                  rst_d = '0;
               end
            end

            ST_ERR: begin
               rst_d = '1;
               to_d  = 1'b1;
            end

            default: begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               idx_d   = '0;
               rst_d   = '1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '1;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         to_q    <= to_d;
      end
   end

   assign rst_o      = rst_q;
   assign rdy_sync_o = rdy_sync;
   assign state_o    = state_q;
   assign timeout_o  = to_q;

endmodule

// File: tb/tb_iob_reset_seq.sv
// Self-checking bench for iob_reset_seq: elapsed-time reference model plus directed scenarios.
module tb_iob_reset_seq;

   localparam int unsigned N_RDY     = 2;
   localparam int unsigned N_OUT     = 2;
   localparam int unsigned HOLD_CYC  = 16;
   localparam int unsigned STAGE_CYC = 4;
   localparam int unsigned TO_CYC    = 64;

   localparam int M_HOLD = 0, M_WAIT = 1, M_STAGE = 2, M_RUN = 3, M_ERR = 4;

   logic             clk;
   logic             resetn;
   logic             soft_rst_i;
   logic [N_RDY-1:0] rdy_i;
   logic [N_OUT-1:0] rst_o;
   logic [N_RDY-1:0] rdy_sync_o;
   logic [2:0]       state_o;
   logic             timeout_o;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 0;

   iob_reset_seq #(
      .N_RDY     (N_RDY),
      .N_OUT     (N_OUT),
      .HOLD_CYC  (HOLD_CYC),
      .STAGE_CYC (STAGE_CYC),
      .TO_CYC    (TO_CYC)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .soft_rst_i (soft_rst_i),
      .rdy_i      (rdy_i),
      .rst_o      (rst_o),
      .rdy_sync_o (rdy_sync_o),
      .state_o    (state_o),
      .timeout_o  (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: mode plus cycles elapsed in that mode; resets derived from elapsed time.
   int               m_mode;
   int               m_t;
   bit               m_to;
   logic [N_RDY-1:0] m_dly [0:1];

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_mode   = M_HOLD;
         m_t      = 0;
         m_to     = 0;
         m_dly[0] = '0;
         m_dly[1] = '0;
      end else begin
         bit all_ok;
         all_ok   = &m_dly[1];
         m_dly[1] = m_dly[0];
         m_dly[0] = rdy_i;
         if (soft_rst_i) begin
            m_mode = M_HOLD; m_t = 0; m_to = 0;
         end else begin
            case (m_mode)
               M_HOLD: begin
                  m_t++;
                  if (m_t == HOLD_CYC) begin m_mode = M_WAIT; m_t = 0; end
               end
               M_WAIT: begin
                  if (all_ok) begin m_mode = M_STAGE; m_t = 0; end
                  else begin
                     m_t++;
                     if (m_t == TO_CYC) begin m_mode = M_ERR; m_t = 0; m_to = 1; end
                  end
               end
               M_STAGE: begin
                  if (!all_ok) begin m_mode = M_HOLD; m_t = 0; end
                  else begin
                     m_t++;
                     if (m_t == N_OUT * STAGE_CYC) begin m_mode = M_RUN; m_t = 0; end
                  end
               end
               M_RUN: if (!all_ok) begin m_mode = M_HOLD; m_t = 0; end
               default: ;
            endcase
         end
      end
   end

   function automatic logic [N_OUT-1:0] model_rst();
      logic [N_OUT-1:0] r;
      r = '1;
      if (m_mode == M_RUN) r = '0;
      else if (m_mode == M_STAGE)
         for (int k = 0; k < N_OUT; k++) r[k] = (m_t < (k + 1) * STAGE_CYC);
      return r;
   endfunction

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en && resetn) begin
         chk("rst_o",      32'(rst_o),      32'(model_rst()));
         chk("state_o",    32'(state_o),    32'(m_mode));
         chk("timeout_o",  32'(timeout_o),  32'(m_to));
         chk("rdy_sync_o", 32'(rdy_sync_o), 32'(m_dly[1]));
         chk("no_x", 32'($isunknown({rst_o, rdy_sync_o, state_o, timeout_o})), 32'(0));
      end
   end

   task automatic wait_state(input logic [2:0] st, input int budget);
      int n;
      n = 0;
      while (state_o !== st && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_state", 32'(state_o), 32'(st));
   endtask

   initial begin
      int f0, f1, e;
      bit both_low;
      resetn = 1'b0; soft_rst_i = 1'b0; rdy_i = 2'b11;
      repeat (5) @(negedge clk);
      chk("rst_rst_o",   32'(rst_o),      32'h3);
      chk("rst_state",   32'(state_o),    32'h0);
      chk("rst_timeout", 32'(timeout_o),  32'h0);
      chk("rst_sync",    32'(rdy_sync_o), 32'h0);
      resetn = 1'b1;
      check_en = 1;

      // Power-up: release edge numbers counted from reset deassertion.
      f0 = 0; f1 = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (!rst_o[0] && f0 == 0) f0 = i;
         if (!rst_o[1] && f1 == 0) f1 = i;
      end
      chk("rel0_edge", 32'(f0), 32'd21);
      chk("rel1_edge", 32'(f1), 32'd25);
      chk("run_state", 32'(state_o), 32'd3);

      // Missing ready flag: abort, hold, then timeout after the full wait window.
      @(negedge clk); rdy_i = 2'b01;
      e = 0;
      while (timeout_o !== 1'b1 && e < 300) begin @(negedge clk); e++; end
      chk("timeout_edge", 32'(e), 32'd83);
      chk("err_state",    32'(state_o), 32'd4);
      repeat (5) @(negedge clk);
      chk("err_sticky",   32'(timeout_o), 32'd1);
      soft_rst_i = 1'b1; @(negedge clk); soft_rst_i = 1'b0;
      chk("soft_clr_to",    32'(timeout_o), 32'd0);
      chk("soft_clr_state", 32'(state_o),   32'd0);

      // Ready loss in RUN reasserts resets three edges after the drop.
      rdy_i = 2'b11;
      wait_state(3'd3, 200);
      rdy_i = 2'b01;
      @(negedge clk); @(negedge clk);
      chk("drop_e2", 32'(rst_o), 32'h0);
      @(negedge clk);
      chk("drop_e3", 32'(rst_o), 32'h3);
      rdy_i = 2'b11;
      wait_state(3'd3, 200);

      // Soft restart coincident with the final release, then a held level.
      soft_rst_i = 1'b1; @(negedge clk); soft_rst_i = 1'b0;
      wait_state(3'd2, 200);
      repeat (7) @(negedge clk);
      chk("pre_last_rel", 32'(rst_o), 32'h1 << 1);
      soft_rst_i = 1'b1; @(negedge clk); soft_rst_i = 1'b0;
      chk("soft_vs_rel_rst",   32'(rst_o),   32'h3);
      chk("soft_vs_rel_state", 32'(state_o), 32'd0);
      soft_rst_i = 1'b1; repeat (6) @(negedge clk); soft_rst_i = 1'b0;
      chk("soft_level_state", 32'(state_o), 32'd0);

      // Asynchronous reset in the middle of staging.
      wait_state(3'd2, 200);
      repeat (5) @(negedge clk);
      chk("mid_stage_rst", 32'(rst_o), 32'h2);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_o",   32'(rst_o),      32'h3);
      chk("async_state",   32'(state_o),    32'h0);
      chk("async_timeout", 32'(timeout_o),  32'h0);
      chk("async_sync",    32'(rdy_sync_o), 32'h0);
      @(negedge clk); resetn = 1'b1;

      // Toggling ready flags must never expose both domains out of reset.
      wait_state(3'd3, 200);
      both_low = 0;
      for (int i = 0; i < 60; i++) begin
         rdy_i = (i % 2 == 0) ? 2'b00 : 2'b11;
         @(negedge clk);
         if (rst_o == 2'b00 && state_o != 3'd3) both_low = 1;
      end
      chk("toggle_no_release", 32'(both_low), 32'd0);
      chk("toggle_not_run",    32'(state_o != 3'd3), 32'd1);
      rdy_i = 2'b11;
      wait_state(3'd3, 200);

      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      $fatal(1);
   end

endmodule
